// File: rtl/gam_connection_controller.sv
// Edge-memory sequencer for the GAM memory layer: refreshes the s1-s2 edge, ages other s1 edges, deletes stale ones.
// Define CONN_DELETE_COUNT_EN to add the del_count output (edges deleted during the last pass).
module gam_connection_controller #(
  parameter int NODE_W  = 6,
  parameter int AGE_W   = 4,
  parameter int AGE_MAX = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NODE_W-1:0]     s1_idx,
  input  logic [NODE_W-1:0]     s2_idx,
  input  logic [NODE_W:0]       node_count,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [2*NODE_W-1:0]   edge_addr,
  output logic                  edge_we,
  output logic [AGE_W:0]        edge_wdata,
  input  logic [AGE_W:0]        edge_rdata
`ifdef CONN_DELETE_COUNT_EN
  ,
  output logic [NODE_W:0]       del_count
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_WAIT,
    WR_FWD,
    WR_REV,
    NEXT,
    DONE
  } state_e;

  localparam logic [AGE_W:0] AGE_LIMIT = (AGE_W + 1)'(AGE_MAX);

  state_e                state_q, state_d;
  logic [NODE_W-1:0]     j_q, j_d;
  logic [NODE_W-1:0]     s1_q, s1_d;
  logic [NODE_W-1:0]     s2_q, s2_d;
  logic [NODE_W:0]       nc_q, nc_d;
  logic [AGE_W:0]        wdata_q, wdata_d;
  logic [2*NODE_W-1:0]   addr_q, addr_d;
  logic                  we_q, we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
`ifdef CONN_DELETE_COUNT_EN
  logic [NODE_W:0]       del_q, del_d;
`endif

  logic                  illegal_req;
  logic                  last_j;
  logic [AGE_W:0]        age_n;

  assign illegal_req = (s1_idx == s2_idx)
                    || ({1'b0, s1_idx} >= node_count)
                    || ({1'b0, s2_idx} >= node_count);

  // j is widened so node_count = 2^NODE_W terminates without wrapping.
  assign last_j = ({1'b0, j_q} == (nc_q - (NODE_W + 1)'(1)));
  assign age_n  = {1'b0, edge_rdata[AGE_W-1:0]} + (AGE_W + 1)'(1);

  // State register: every output is a flop, so reset clears the RAM port at once.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      j_q     <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      nc_q    <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef CONN_DELETE_COUNT_EN
      del_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      nc_q    <= nc_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef CONN_DELETE_COUNT_EN
      del_q   <= del_d;
`endif
    end
  end

  // Next-state and datapath.
  // NOTE: every signal gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    nc_d    = nc_q;
    wdata_d = wdata_q;
`ifdef CONN_DELETE_COUNT_EN
    del_d   = del_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          s1_d = s1_idx;
          s2_d = s2_idx;
          nc_d = node_count;
          if (illegal_req) begin
            state_d = DONE;
          end else begin
            j_d     = '0;
            state_d = RD;
`ifdef CONN_DELETE_COUNT_EN
            del_d   = '0;
`endif
          end
        end
      end
      RD: state_d = RD_WAIT;
      RD_WAIT: begin
        if (j_q == s1_q) begin
          state_d = NEXT;
        end else if (j_q == s2_q) begin
          wdata_d = {1'b1, {AGE_W{1'b0}}};
          state_d = WR_FWD;
        end else if (edge_rdata[AGE_W]) begin
          state_d = WR_FWD;
          if (age_n > AGE_LIMIT) begin
            wdata_d = '0;
`ifdef CONN_DELETE_COUNT_EN
            del_d   = del_q + (NODE_W + 1)'(1);
`endif
          end else begin
            wdata_d = {1'b1, age_n[AGE_W-1:0]};
          end
        end else begin
          state_d = NEXT;
        end
      end
      WR_FWD: state_d = WR_REV;
      WR_REV: state_d = NEXT;
      NEXT: begin
        if (last_j) begin
          state_d = DONE;
        end else begin
          j_d     = j_q + NODE_W'(1);
          state_d = RD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state so they are registered yet aligned with it.
  always_comb begin
    addr_d = addr_q;
    we_d   = 1'b0;
    unique case (state_d)
      RD:      addr_d = {s1_d, j_d};
      WR_FWD: begin
        addr_d = {s1_d, j_d};
        we_d   = 1'b1;
      end
      WR_REV: begin
        addr_d = {j_d, s1_d};
        we_d   = 1'b1;
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    err_d  = (state_q == IDLE) && start && illegal_req;
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign edge_addr  = addr_q;
  assign edge_we    = we_q;
  assign edge_wdata = wdata_q;
`ifdef CONN_DELETE_COUNT_EN
  assign del_count  = del_q;
`endif

endmodule

// File: tb/tb_gam_connection_controller.sv
// Self-checking bench for gam_connection_controller: edge-RAM model, cycle-schedule reference model, per-cycle compare.
// Honours CONN_DELETE_COUNT_EN when defined.
module tb_gam_connection_controller;

  localparam int NODE_W  = 6;
  localparam int AGE_W   = 4;
  localparam int AGE_MAX = 10;
  localparam int NN      = 1 << NODE_W;
  localparam int DEPTH   = NN * NN;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                start = 1'b0;
  logic [NODE_W-1:0]   s1_idx = '0;
  logic [NODE_W-1:0]   s2_idx = '0;
  logic [NODE_W:0]     node_count = '0;
  logic                busy, done, err, edge_we;
  logic [2*NODE_W-1:0] edge_addr;
  logic [AGE_W:0]      edge_wdata;
  logic [AGE_W:0]      edge_rdata;
`ifdef CONN_DELETE_COUNT_EN
  logic [NODE_W:0]     del_count;
`endif

  always #5 clk = ~clk;

  gam_connection_controller #(
    .NODE_W (NODE_W),
    .AGE_W  (AGE_W),
    .AGE_MAX(AGE_MAX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .s1_idx    (s1_idx),
    .s2_idx    (s2_idx),
    .node_count(node_count),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .edge_addr (edge_addr),
    .edge_we   (edge_we),
    .edge_wdata(edge_wdata),
    .edge_rdata(edge_rdata)
`ifdef CONN_DELETE_COUNT_EN
    ,
    .del_count (del_count)
`endif
  );

  // Edge RAM with one-cycle synchronous read; bulk-loaded from init_ram by the bench.
  logic [AGE_W:0] ram       [DEPTH];
  logic [AGE_W:0] init_ram  [DEPTH];
  logic [AGE_W:0] model_ram [DEPTH];
  logic [AGE_W:0] pre_ram   [DEPTH];
  logic           load = 1'b0;

  always @(posedge clk) begin
    edge_rdata <= ram[edge_addr];
    if (load) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_ram[i];
    end else if (edge_we) begin
      ram[edge_addr] <= edge_wdata;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit busy;
    bit done;
    bit err;
    bit we;
    bit chk_addr;
    int addr;
    int wdata;
  } exp_t;

  exp_t exp_q[$];

  task automatic push_exp(input bit b, input bit d, input bit e, input bit w,
                          input bit ca, input int a, input int wd);
    exp_t x;
    x.busy = b; x.done = d; x.err = e; x.we = w; x.chk_addr = ca; x.addr = a; x.wdata = wd;
    exp_q.push_back(x);
  endtask

  // One compare process: pops the expected cycle while a pass is scheduled, else expects idle.
  always @(negedge clk) begin
    if (reset) begin
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("busy", 32'(busy), 32'(e.busy));
        check("done", 32'(done), 32'(e.done));
        check("err",  32'(err),  32'(e.err));
        check("edge_we", 32'(edge_we), 32'(e.we));
        if (e.chk_addr || e.we) check("edge_addr", 32'(edge_addr), e.addr);
        if (e.we) check("edge_wdata", 32'(edge_wdata), e.wdata);
      end else begin
        check("idle_we",   32'(edge_we), 32'd0);
        check("idle_done", 32'(done),    32'd0);
      end
    end
  end

  // Reference model: per-j cycle schedule (3 skip / 5 write), then DONE, then one idle cycle.
  task automatic build_model(input int s1, input int s2, input int nc,
                             output int done_idx, output int n_wr, output int dels);
    logic [AGE_W:0] cur;
    int             age;
    int             nv;
    bit             wr;
    n_wr = 0;
    dels = 0;
    if (s1 == s2 || s1 >= nc || s2 >= nc) begin
      done_idx = 0;
      push_exp(1, 1, 1, 0, 0, 0, 0);
    end else begin
      for (int j = 0; j < nc; j++) begin
        push_exp(1, 0, 0, 0, 1, s1 * NN + j, 0);
        push_exp(1, 0, 0, 0, 0, 0, 0);
        cur = model_ram[s1 * NN + j];
        wr  = 0;
        nv  = 0;
        if (j == s1) begin
          wr = 0;
        end else if (j == s2) begin
          wr = 1;
          nv = 1 << AGE_W;
        end else if (cur[AGE_W]) begin
          wr  = 1;
          age = int'(cur[AGE_W-1:0]) + 1;
          if (age > AGE_MAX) begin
            nv = 0;
            dels++;
          end else begin
            nv = (1 << AGE_W) + age;
          end
        end
        if (wr) begin
          push_exp(1, 0, 0, 1, 1, s1 * NN + j, nv);
          push_exp(1, 0, 0, 1, 1, j * NN + s1, nv);
          model_ram[s1 * NN + j] = (AGE_W + 1)'(nv);
          model_ram[j * NN + s1] = (AGE_W + 1)'(nv);
          n_wr += 2;
        end
        push_exp(1, 0, 0, 0, 0, 0, 0);
      end
      done_idx = exp_q.size();
      push_exp(1, 1, 0, 0, 0, 0, 0);
    end
    push_exp(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic clear_init();
    for (int i = 0; i < DEPTH; i++) init_ram[i] = '0;
  endtask

  task automatic set_edge(input int a, input int b, input logic [AGE_W:0] v);
    init_ram[a * NN + b] = v;
    init_ram[b * NN + a] = v;
  endtask

  task automatic load_ram();
    for (int i = 0; i < DEPTH; i++) model_ram[i] = init_ram[i];
    @(posedge clk); #1 load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
  endtask

  task automatic random_fill(input int nc);
    clear_init();
    for (int i = 0; i < nc; i++) begin
      for (int j = i + 1; j < nc; j++) begin
        case ($urandom % 4)
          0: set_edge(i, j, {1'b1, AGE_W'($urandom_range(0, AGE_MAX))});
          1: set_edge(i, j, {1'b0, AGE_W'($urandom)});
          default: ;
        endcase
      end
    end
    load_ram();
  endtask

  task automatic compare_ram(input string name);
    int mism = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== model_ram[i]) mism++;
    check(name, 32'(mism), 32'd0);
  endtask

  task automatic issue_start(input int s1, input int s2, input int nc);
    @(posedge clk); #1;
    start      = 1'b1;
    s1_idx     = NODE_W'(s1);
    s2_idx     = NODE_W'(s2);
    node_count = (NODE_W + 1)'(nc);
    @(posedge clk); #1;
    start      = 1'b0;
    s1_idx     = NODE_W'($urandom);
    s2_idx     = NODE_W'($urandom);
    node_count = (NODE_W + 1)'($urandom);
  endtask

  task automatic run_req(input int s1, input int s2, input int nc, input bit poke,
                         output int done_idx, output int n_wr, output int dels);
    int c = 0;
    issue_start(s1, s2, nc);
    build_model(s1, s2, nc, done_idx, n_wr, dels);
    while (exp_q.size() > 0 && c < 2000) begin
      @(posedge clk); #1;
      start = poke && (c == 4);
      c++;
    end
    start = 1'b0;
    check("timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    compare_ram("ram_image");
`ifdef CONN_DELETE_COUNT_EN
    check("del_count", 32'(del_count), 32'(dels));
`endif
  endtask

  initial begin
    int  di, nw, nd, nc, s1, s2;
    bit  seen;

    clear_init();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_done",  32'(done),       32'd0);
    check("rst_err",   32'(err),        32'd0);
    check("rst_we",    32'(edge_we),    32'd0);
    check("rst_addr",  32'(edge_addr),  32'd0);
    check("rst_wdata", 32'(edge_wdata), 32'd0);
    reset = 1'b1;
    load_ram();

    // 1: empty RAM, one edge created; done 11 cycles after RD.
    run_req(0, 1, 3, 0, di, nw, nd);
    check("s1_done_idx", 32'(di), 32'd11);
    check("s1_n_writes", 32'(nw), 32'd2);
    check("s1_e01", 32'(ram[1]),  32'h10);
    check("s1_e10", 32'(ram[NN]), 32'h10);

    // 2: ageing of a neighbour edge.
    clear_init(); set_edge(0, 2, 5'h14); load_ram();
    run_req(0, 1, 3, 0, di, nw, nd);
    check("s2_e02", 32'(ram[2]),      32'h15);
    check("s2_e20", 32'(ram[2 * NN]), 32'h15);
    check("s2_e01", 32'(ram[1]),      32'h10);

    // 3: edge at AGE_MAX is deleted.
    clear_init(); set_edge(0, 2, 5'h1A); load_ram();
    run_req(0, 1, 3, 0, di, nw, nd);
    check("s3_e02", 32'(ram[2]),      32'h00);
    check("s3_e20", 32'(ram[2 * NN]), 32'h00);
    check("s3_model_dels", 32'(nd), 32'd1);

    // 4: refresh of an existing s1-s2 edge.
    clear_init(); set_edge(0, 1, 5'h17); load_ram();
    run_req(0, 1, 3, 0, di, nw, nd);
    check("s4_e01", 32'(ram[1]), 32'h10);
    check("s4_n_writes", 32'(nw), 32'd2);

    // 5: illegal requests finish in one cycle with err.
    run_req(5, 1, 4, 0, di, nw, nd);
    check("s5_done_idx", 32'(di), 32'd0);
    run_req(2, 2, 4, 0, di, nw, nd);
    run_req(1, 4, 4, 0, di, nw, nd);

    // 6: reset during WR_FWD aborts without a write.
    clear_init(); load_ram();
    for (int i = 0; i < DEPTH; i++) pre_ram[i] = model_ram[i];
    issue_start(0, 1, 3);
    build_model(0, 1, 3, di, nw, nd);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #2;
      seen = edge_we;
    end
    check("s6_we_seen", 32'(seen), 32'd1);
    exp_q.delete();
    reset = 1'b0;
    #1;
    check("s6_we",   32'(edge_we), 32'd0);
    check("s6_busy", 32'(busy),    32'd0);
    check("s6_addr", 32'(edge_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++) model_ram[i] = pre_ram[i];
    compare_ram("s6_no_write");
    reset = 1'b1;
    run_req(0, 1, 3, 0, di, nw, nd);
    check("s6_restart_done_idx", 32'(di), 32'd11);

    // Boundary: node_count = 2^NODE_W with the top node as s1.
    random_fill(NN);
    run_req(NN - 1, 0, NN, 1, di, nw, nd);

    // Randomised passes, including illegal indices and start pulses while busy.
    for (int it = 0; it < 15; it++) begin
      nc = $urandom_range(2, 8);
      random_fill(nc);
      s1 = $urandom_range(0, nc);
      s2 = $urandom_range(0, nc);
      run_req(s1, s2, nc, (it % 3) == 0, di, nw, nd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
